halt_dump_controller: RTL and testbench
=======================================

// Module: halt_dump_controller
// PURPOSE
//  Run/halt sequencer for the pipelined CPU. Watches the IF/ID instruction for the halt word and
//  lets the pipeline drain. It then freezes the CPU and takes over the data-memory port.
//  It streams all MEM_WORDS data words out over a valid/ready dump port and reports the cycle count.
//  Sits between cpu core and mainmemory; replaces bench-side hierarchical peeking.
// PARAMETERS
//  HALT_WORD     32'hFFFFFFFF  instruction encoding that ends the program
//  DRAIN_CYCLES  2             cycles after halt detection before memory is taken over (>=0)
//  MEM_WORDS     512           number of data-RAM words dumped
//  ADDR_W        9             data-RAM word-address width (2**ADDR_W >= MEM_WORDS)
//  DATA_W        32            data word width
// PORTS
//  CLOCK          in   1       single clock, rising edge
//  RESET          in   1       asynchronous, active-high reset
//  instr_id       in   32      instruction currently latched in IF/ID
//  cpu_mem_we     in   1       CPU data-memory write enable (MEM stage)
//  cpu_mem_addr   in   ADDR_W  CPU data-memory word address
//  cpu_mem_wdata  in   DATA_W  CPU data-memory write data
//  mem_we         out  1       write enable to data RAM (muxed)
//  mem_addr       out  ADDR_W  address to data RAM (muxed)
//  mem_wdata      out  DATA_W  write data to data RAM (muxed)
//  mem_rdata      in   DATA_W  data RAM read data, combinational (same-cycle) read
//  cpu_stall      out  1       freezes PC and all pipeline registers when 1
//  dump_valid     out  1       dump_data/dump_addr hold a valid word
//  dump_ready     in   1       consumer accepts the word this cycle
//  dump_addr      out  ADDR_W  word address of dump_data
//  dump_data      out  DATA_W  dumped word
//  cycle_count    out  32      cycles executed, including halt + drain cycles
//  done           out  1       dump complete; sticky until RESET
// BEHAVIOUR
//  - States: RUN -> DRAIN -> DUMP -> DONE. RESET (any time, any state) forces:
//    RUN, cycle_count=0, drain_cnt=0, dump_ptr=0, cpu_stall=0, dump_valid=0, done=0.
//  - RUN: CPU owns the memory port (mem_* = cpu_mem_*). cycle_count += 1 every edge.
//    At an edge with instr_id==HALT_WORD: go to DRAIN, or straight to DUMP if DRAIN_CYCLES==0.
//  - DRAIN: CPU still owns the port, so in-flight stores complete. cycle_count += 1 every edge.
//    drain_cnt counts edges; on the DRAIN_CYCLES-th edge go to DUMP.
//  - DUMP: cpu_stall=1. mem_we=0, mem_wdata=0, mem_addr=dump_ptr.
//    dump_valid=1, dump_addr=dump_ptr, dump_data=mem_rdata.
//    On an edge with dump_valid&&dump_ready, dump_ptr += 1.
//    A handshake with dump_ptr==MEM_WORDS-1 goes to DONE.
//    While dump_ready=0, dump_addr/dump_data hold stable. cycle_count is frozen.
//  - DONE: cpu_stall=1, mem_we=0, dump_valid=0, done=1, cycle_count frozen.
//    Exited only by RESET.
//  - cycle_count saturates at 32'hFFFFFFFF; it never wraps.
//  - A second HALT_WORD seen in DRAIN/DUMP/DONE is ignored.
//  - In DUMP, cpu_mem_we is ignored and never reaches the RAM.
//  - dump_ptr is ADDR_W wide. No wrap occurs because the exit happens at MEM_WORDS-1.
//  - The state register and counters are reset asynchronously. All outputs are decoded from registered state.
//    No output is combinational from instr_id or dump_ready.
// STRUCTURE
//  - Shared header cpu_defs.vh: HALT_WORD constant, state encodings ST_RUN=2'd0, ST_DRAIN=2'd1,
//    ST_DUMP=2'd2, ST_DONE=2'd3, DATA_W/ADDR_W defaults.
//  - One sub-module: mem_port_mux. It is a combinational 2:1 mux of {we,addr,wdata}, sel = (state==DUMP||DONE).
//    we is forced to 0 when sel=1.
//  - Top holds the FSM, drain counter, dump pointer and cycle counter.
// TESTING
//  1. Reset, then instr_id=0 for 10 edges, then HALT_WORD held -> DRAIN after edge 11.
//     DUMP after edge 13, cycle_count==13 and frozen thereafter.
//  2. Store 0xDEADBEEF to addr 5 during the 2nd DRAIN cycle, dump_ready=1 -> word 5 dumps as 0xDEADBEEF.
//     Exactly 512 handshakes occur; done=1 the edge after the addr-511 handshake.
//  3. dump_ready toggles 1,0,0,1 starting at addr 0 -> addr 1 data held for 3 cycles.
//     No skipped or duplicated address, and dump_addr is monotonic 0..511.
//  4. cpu_mem_we=1 to addr 7, value 0x1234, while in DUMP -> RAM word 7 unchanged.
//     cpu_stall=1 throughout DUMP and DONE.
//  5. Assert RESET mid-DUMP at dump_ptr=100 -> all outputs return to reset values asynchronously.
//     After the rerun to halt, the dump restarts at addr 0.
//  6. DRAIN_CYCLES=0 build, halt after 4 edges -> DUMP directly, cycle_count==5.
//     The HALT_WORD held through DUMP causes no re-entry or extra count.

Source files
------------

// File: rtl/halt_dump_controller_pkg.sv
// Shared definitions for the halt/dump sequencer.
//   state_t        : sequencer states (RUN -> DRAIN -> DUMP -> DONE)
//   *_DEFAULT      : default halt word and bus widths
//   owns_mem_port  : true in the states where the sequencer drives the RAM port
package halt_dump_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          DATA_W_DEFAULT    = 32;
    localparam int          ADDR_W_DEFAULT    = 9;

    // Once the dump starts, the CPU never gets the memory port back until reset.
    function automatic logic owns_mem_port(input state_t s);
        return (s == ST_DUMP) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/halt_dump_controller_mem_port_mux.sv
// Data-RAM port multiplexer.
//   i_sel        : 1 = sequencer owns the port, 0 = CPU owns it
//   i_cpu_*      : CPU write enable / address / write data
//   i_dump_addr  : sequencer read address
//   o_mem_*      : muxed write enable / address / write data to the RAM
// When the sequencer owns the port the write enable is forced low so a
// frozen CPU store can never corrupt the memory being dumped.
module mem_port_mux #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              i_sel,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    input  logic [ADDR_W-1:0] i_dump_addr,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    always_comb begin
        if (i_sel) begin
            o_mem_we    = 1'b0;
            o_mem_addr  = i_dump_addr;
            o_mem_wdata = '0;
        end else begin
            o_mem_we    = i_cpu_we;
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
        end
    end

endmodule

// File: rtl/halt_dump_controller.sv
// Run/halt sequencer: detects the halt instruction in IF/ID, lets the
// pipeline drain, freezes the CPU, then streams the whole data RAM out of
// the dump port and reports how many cycles the program took.
// Ports:
//   CLOCK, RESET                 : clock, asynchronous active-high reset
//   instr_id                     : instruction latched in IF/ID
//   cpu_mem_we/addr/wdata        : CPU data-memory request (MEM stage)
//   mem_we/addr/wdata, mem_rdata : data-RAM port (rdata is same-cycle)
//   cpu_stall                    : freezes PC and pipeline registers
//   dump_valid/ready/addr/data   : dump stream
//   cycle_count                  : executed cycles, saturating
//   done                         : dump finished, sticky until reset
//   dbg_state                    : current sequencer state
// Dump handshake: a word transfers on a rising edge where dump_valid and
// dump_ready are both 1; while dump_valid=1 and dump_ready=0, dump_addr and
// dump_data stay unchanged.
module halt_dump_controller
    import halt_dump_controller_pkg::*;
#(
    parameter logic [31:0] HALT_WORD    = HALT_WORD_DEFAULT,
    parameter int          DRAIN_CYCLES = 2,
    parameter int          MEM_WORDS    = 512,
    parameter int          ADDR_W       = ADDR_W_DEFAULT,
    parameter int          DATA_W       = DATA_W_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [31:0]       instr_id,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [31:0]       cycle_count,
    output logic              done,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
    // Unused when DRAIN_CYCLES==0 because DRAIN is then never entered.
    localparam logic [31:0]       DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_drain_cnt;
    logic [ADDR_W-1:0] r_dump_ptr;
    logic [31:0]       r_cycle_count;

    logic w_halt;
    logic w_handshake;
    logic w_last_word;
    logic w_drain_done;
    logic w_sel;

    assign w_halt       = (instr_id == HALT_WORD);
    assign w_handshake  = (r_state == ST_DUMP) && dump_ready;
    assign w_last_word  = (r_dump_ptr == LAST_ADDR);
    assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

    // State register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt words outside RUN are simply not looked at.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_halt) begin
                    w_next_state = (DRAIN_CYCLES == 0) ? ST_DUMP : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next_state = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (w_handshake && w_last_word) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Output decode, purely from registered state (dump_data follows the RAM).
    always_comb begin
        w_sel      = owns_mem_port(r_state);
        cpu_stall  = w_sel;
        dump_valid = (r_state == ST_DUMP);
        done       = (r_state == ST_DONE);
        dump_addr  = r_dump_ptr;
        dump_data  = (r_state == ST_DUMP) ? mem_rdata : '0;
    end

    // Drain counter: counts edges spent in DRAIN.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 32'd1;
        end
    end

    // Dump pointer: the last handshake does not advance it, so it never wraps.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_dump_ptr <= '0;
        end else if (w_handshake && !w_last_word) begin
            r_dump_ptr <= r_dump_ptr + 1'b1;
        end
    end

    // Cycle counter: runs through RUN and DRAIN (including the transition
    // edges), frozen afterwards, saturating at all-ones.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_cycle_count <= '0;
        end else if (((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
    assign dbg_state   = r_state;

    mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_port_mux (
        .i_sel       (w_sel),
        .i_cpu_we    (cpu_mem_we),
        .i_cpu_addr  (cpu_mem_addr),
        .i_cpu_wdata (cpu_mem_wdata),
        .i_dump_addr (r_dump_ptr),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_halt_dump_controller.sv
module tb_halt_dump_controller;
    import halt_dump_controller_pkg::*;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic rst_b = 1'b1;

    initial forever #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT A (DRAIN_CYCLES = 2) ----------------
    logic [31:0] instr_id = '0;
    logic        cpu_mem_we = 1'b0;
    logic [8:0]  cpu_mem_addr = '0;
    logic [31:0] cpu_mem_wdata = '0;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_stall;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [8:0]  dump_addr;
    logic [31:0] dump_data;
    logic [31:0] cycle_count;
    logic        done;
    state_t      dbg_state;

    halt_dump_controller #(.DRAIN_CYCLES(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .instr_id(instr_id),
        .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .cycle_count(cycle_count),
        .done(done), .dbg_state(dbg_state)
    );

    // Initial RAM content is a fixed pattern; written words overlay it.
    function automatic logic [31:0] pat(input logic [8:0] a);
        return 32'h5A00_0000 ^ ({23'd0, a} * 32'h0001_0003);
    endfunction

    // Expected content after test 2's store (the RAM is never reset).
    function automatic logic [31:0] exp_word(input int a);
        logic [8:0] aa;
        aa = a[8:0];
        return (a == 5) ? 32'hDEAD_BEEF : pat(aa);
    endfunction

    logic [31:0] ram [512];
    bit          written [512];

    always @(posedge CLOCK) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr] ? ram[mem_addr] : pat(mem_addr);

    // ---------------- DUT B (DRAIN_CYCLES = 0) ----------------
    logic [31:0] instr_b = '0;
    logic        mem_we_b;
    logic [8:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [31:0] mem_rdata_b;
    logic        cpu_stall_b;
    logic        dump_valid_b;
    logic        dump_ready_b = 1'b0;
    logic [8:0]  dump_addr_b;
    logic [31:0] dump_data_b;
    logic [31:0] cycle_count_b;
    logic        done_b;
    state_t      dbg_state_b;

    assign mem_rdata_b = {23'd0, mem_addr_b};

    halt_dump_controller #(.DRAIN_CYCLES(0)) dut_b (
        .CLOCK(CLOCK), .RESET(rst_b), .instr_id(instr_b),
        .cpu_mem_we(1'b0), .cpu_mem_addr(9'd0), .cpu_mem_wdata(32'd0),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .cpu_stall(cpu_stall_b), .dump_valid(dump_valid_b), .dump_ready(dump_ready_b),
        .dump_addr(dump_addr_b), .dump_data(dump_data_b), .cycle_count(cycle_count_b),
        .done(done_b), .dbg_state(dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    logic [40:0] exp_q [$];   // {addr[8:0], data[31:0]}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_dump(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            exp_q.push_back({a[8:0], exp_word(a)});
        end
    endtask

    // Sample the current cycle; on a handshake pop and compare.
    task automatic observe(inout int hs);
        logic [40:0] e;
        if (dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("dump_addr", {23'd0, dump_addr}, {23'd0, e[40:32]});
                check("dump_data", dump_data, e[31:0]);
            end
            hs++;
        end
    endtask

    task automatic reset_a_checks(input string tag);
        check({tag, "_count"}, cycle_count, 32'd0);
        check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
        check({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_RUN));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hs;
        int cyc;

        // Test 1: reset, 10 plain edges, halt, drain.
        tick();
        tick();
        reset_a_checks("rst");
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t1_count10", cycle_count, 32'd10);
        check("t1_run", 32'(dbg_state), 32'(ST_RUN));
        instr_id = HALT;
        tick();
        check("t1_drain", 32'(dbg_state), 32'(ST_DRAIN));
        check("t1_count11", cycle_count, 32'd11);
        tick();
        // Test 2: store during the second drain cycle still reaches the RAM.
        cpu_mem_we    = 1'b1;
        cpu_mem_addr  = 9'd5;
        cpu_mem_wdata = 32'hDEAD_BEEF;
        #1;
        check("t2_drain_we", {31'd0, mem_we}, 32'd1);
        check("t2_drain_stall", {31'd0, cpu_stall}, 32'd0);
        tick();
        check("t1_dump", 32'(dbg_state), 32'(ST_DUMP));
        check("t1_count13", cycle_count, 32'd13);

        // Tests 2/3/4: full dump with a 1,0,0,1 ready prefix then random.
        push_dump(0, 511);
        hs  = 0;
        cyc = 0;
        while (hs < 512 && cyc < 5000) begin
            if (cyc < 4) dump_ready = (cyc == 0) || (cyc == 3);
            else         dump_ready = 1'($urandom_range(0, 1));
            if (cyc == 0) begin
                cpu_mem_we    = 1'b1;
                cpu_mem_addr  = 9'd7;
                cpu_mem_wdata = 32'h0000_1234;
            end else begin
                cpu_mem_we = 1'b0;
            end
            #1;
            if (cyc == 0) begin
                check("t4_we_blocked", {31'd0, mem_we}, 32'd0);
                check("t4_stall", {31'd0, cpu_stall}, 32'd1);
            end
            if (cyc >= 1 && cyc <= 3) begin
                check("t3_hold_addr", {23'd0, dump_addr}, 32'd1);
                check("t3_hold_data", dump_data, exp_word(1));
            end
            if (cyc == 200) check("t1_count_frozen", cycle_count, 32'd13);
            observe(hs);
            tick();
            cyc++;
        end
        dump_ready = 1'b0;
        check("t2_handshakes", 32'(hs), 32'd512);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_state_done", 32'(dbg_state), 32'(ST_DONE));
        check("t2_valid_low", {31'd0, dump_valid}, 32'd0);
        check("t4_stall_done", {31'd0, cpu_stall}, 32'd1);
        check("t2_count_final", cycle_count, 32'd13);
        cpu_mem_we = 1'b1;
        #1;
        check("t4_we_done", {31'd0, mem_we}, 32'd0);
        cpu_mem_we = 1'b0;
        tick();
        check("t2_done_sticky", {31'd0, done}, 32'd1);

        // Test 5: reset mid-dump, rerun, dump restarts at 0.
        RESET = 1'b1;
        #1;
        reset_a_checks("t5_rst_done");
        tick();
        RESET    = 1'b0;
        instr_id = 32'd0;
        for (int i = 0; i < 3; i++) tick();
        instr_id = HALT;
        for (int i = 0; i < 3; i++) tick();
        check("t5_dump1", 32'(dbg_state), 32'(ST_DUMP));
        exp_q.delete();
        push_dump(0, 511);
        hs  = 0;
        cyc = 0;
        dump_ready = 1'b1;
        while (hs < 100 && cyc < 1000) begin
            observe(hs);
            tick();
            cyc++;
        end
        check("t5_ptr100", {23'd0, dump_addr}, 32'd100);
        RESET = 1'b1;
        #1;
        reset_a_checks("t5_rst_mid");
        tick();
        RESET      = 1'b0;
        dump_ready = 1'b0;
        instr_id   = 32'd0;
        for (int i = 0; i < 3; i++) tick();
        instr_id = HALT;
        for (int i = 0; i < 3; i++) tick();
        check("t5_dump2", 32'(dbg_state), 32'(ST_DUMP));
        check("t5_count", cycle_count, 32'd6);
        check("t5_restart_addr", {23'd0, dump_addr}, 32'd0);
        check("t5_restart_data", dump_data, exp_word(0));

        // Test 6: DRAIN_CYCLES = 0 instance.
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_count4", cycle_count_b, 32'd4);
        instr_b = HALT;
        tick();
        check("t6_dump", 32'(dbg_state_b), 32'(ST_DUMP));
        check("t6_count5", cycle_count_b, 32'd5);
        check("t6_stall", {31'd0, cpu_stall_b}, 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("t6_no_reentry", 32'(dbg_state_b), 32'(ST_DUMP));
        check("t6_count_held", cycle_count_b, 32'd5);
        dump_ready_b = 1'b1;
        hs  = 0;
        cyc = 0;
        while (!done_b && cyc < 1000) begin
            if (dump_valid_b) hs++;
            tick();
            cyc++;
        end
        check("t6_done", {31'd0, done_b}, 32'd1);
        check("t6_handshakes", 32'(hs), 32'd512);
        check("t6_count_final", cycle_count_b, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
